// File: rtl/rr_arbiter_8_pkg.sv
// rr_arbiter_8_pkg
// Shared definitions for the 8-way round-robin arbiter:
//   NREQ  - number of requesters
//   IDXW  - width of a requester index
//   CNTW  - width of the hold counter
//   arb_state_t - arbiter FSM states (idle / grant held)
//   rr_pick - rotating-priority search over a request vector
package rr_arbiter_8_pkg;

    localparam int NREQ = 8;
    localparam int IDXW = 3;
    localparam int CNTW = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Returns the first set bit of req_vec when scanning start, start+1, ...
    // wrapping modulo NREQ. The vector is rotated so the search start lands
    // on bit 0, then a fixed lowest-bit-first priority finds the offset.
    // Callers only use the result when req_vec has at least one bit set.
    function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] req_vec,
                                               input logic [IDXW-1:0] start);
        logic [2*NREQ-1:0] doubled;
        logic [NREQ-1:0]   rotated;
        logic [IDXW-1:0]   offset;
        doubled = {req_vec, req_vec} >> start;
        rotated = doubled[NREQ-1:0];
        offset  = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                offset = IDXW'(j);
            end
        end
        return start + offset;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_dec3x8.sv
// rr_arbiter_8_dec3x8
// 3-to-8 decoder with enable, used to turn the registered winner index into
// the one-hot grant vector.
//   en  in  1      decoder enable; all outputs low when 0
//   w   in  3      selected output index
//   y   out [0:7]  one-hot output, y[w] high when en=1
module rr_arbiter_8_dec3x8 (
    input  logic       en,
    input  logic [2:0] w,
    output logic [0:7] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[w] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8
// Round-robin arbiter sharing one resource between 8 requesters. The winner
// index and a valid flag are registered; the one-hot grant is decoded from
// those registers only, so it can never glitch or show more than one bit.
// A holder may keep the grant for at most MAX_HOLD consecutive cycles while
// anyone else is waiting (MAX_HOLD legal range 1..15).
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   req        in   8      req[k]=1: requester k wants the resource (level)
//   grant      out  [0:7]  one-hot grant, grant[k] <-> requester k
//   gnt_valid  out  1      high while a grant is active
//   gnt_idx    out  3      index of current holder, valid when gnt_valid=1
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [0:NREQ-1] grant,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx
);

    arb_state_t      state,    state_n;
    logic [IDXW-1:0] ptr,      ptr_n;
    logic [IDXW-1:0] idx_n;
    logic [CNTW-1:0] hold_cnt, cnt_n;

    logic [NREQ-1:0] holder_mask;
    logic [NREQ-1:0] others_req;
    logic            others;
    logic            last_slot;

    // Requests from everyone except the current holder; a release never
    // hands the grant straight back to the requester that just gave it up.
    assign holder_mask = NREQ'(1) << gnt_idx;
    assign others_req  = req & ~holder_mask;
    assign others      = |others_req;
    assign last_slot   = (hold_cnt == CNTW'(MAX_HOLD - 1));

    assign gnt_valid = (state == ST_GRANT);

    // State, search pointer, winner index and hold counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            gnt_idx  <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            gnt_idx  <= idx_n;
            hold_cnt <= cnt_n;
        end
    end

    // Next-state logic. A release (voluntary, or forced once the hold budget
    // is spent while others wait) moves the search start past the holder and
    // hands over in the same edge so back-to-back grants have no idle bubble.
    // A lone holder that exhausts its budget just restarts the counter.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = gnt_idx;
        cnt_n   = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    idx_n   = rr_pick(req, ptr);
                    cnt_n   = '0;
                    state_n = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!req[gnt_idx] || (last_slot && others)) begin
                    ptr_n = gnt_idx + IDXW'(1);
                    if (others) begin
                        idx_n = rr_pick(others_req, gnt_idx + IDXW'(1));
                        cnt_n = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (last_slot) begin
                    cnt_n = '0;
                end else begin
                    cnt_n = hold_cnt + CNTW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    rr_arbiter_8_dec3x8 u_dec (
        .en (gnt_valid),
        .w  (gnt_idx),
        .y  (grant)
    );

endmodule
